// File: rtl/ms_timer_pkg.sv
// Shared definitions for the millisecond countdown timer and its tick supervisor.
package ms_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    localparam int unsigned DEFAULT_CNT_W        = 16;
    localparam int unsigned DEFAULT_TICK_TIMEOUT = 1100;

endpackage

// File: rtl/tick_watchdog.sv
// Flags a missing periodic tick: sets a sticky 'lost' after TIMEOUT enabled cycles
// without a tick. 'clear' restarts supervision and drops the flag.
module tick_watchdog #(
    parameter int unsigned TIMEOUT = 1100
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clear,
    input  logic tick,
    output logic lost
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            lost_q, lost_d;

    always_comb begin
        cnt_d  = cnt_q;
        lost_d = lost_q;
        if (clear) begin
            cnt_d  = '0;
            lost_d = 1'b0;
        end else if (!enable || tick) begin
            cnt_d = '0;
        end else if (cnt_q != Limit) begin
            // Saturate at the limit so a long outage cannot wrap the counter.
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == Limit) begin
                lost_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            lost_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            lost_q <= lost_d;
        end
    end

    assign lost = lost_q;

endmodule

// File: rtl/ms_timer.sv
// Programmable millisecond countdown timer with one-shot / auto-reload modes,
// driven by a 1 ms tick strobe and supervised by a tick watchdog.
module ms_timer
    import ms_timer_pkg::*;
#(
    parameter int unsigned CNT_W        = DEFAULT_CNT_W,
    parameter int unsigned TICK_TIMEOUT = DEFAULT_TICK_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1ms,
    input  logic             start,
    input  logic             stop,
    input  logic [CNT_W-1:0] load_val,
    input  logic             auto_reload,
    output logic             busy,
    output logic [CNT_W-1:0] remaining,
    output logic             expired,
    output logic             tick_lost
);

    localparam logic [CNT_W-1:0] One = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [CNT_W-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             expired_q, expired_d;

    logic start_acc;
    logic wd_enable;

    // stop always wins, so a start is only honoured without a concurrent stop.
    assign start_acc = start && !stop;
    assign wd_enable = (state_q == ST_RUN) && !stop;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        reload_d    = reload_q;
        mode_d      = mode_q;
        expired_d   = 1'b0;

        if (stop) begin
            state_d     = ST_IDLE;
            remaining_d = '0;
        end else if (start) begin
            if (load_val != '0) begin
                state_d     = ST_RUN;
                remaining_d = load_val;
                reload_d    = load_val;
                mode_d      = auto_reload;
            end else begin
                // A zero interval expires immediately and never enters RUN.
                state_d     = ST_IDLE;
                remaining_d = '0;
                expired_d   = 1'b1;
            end
        end else if (state_q == ST_RUN && tick_1ms) begin
            if (remaining_q > One) begin
                remaining_d = remaining_q - One;
            end else begin
                expired_d = 1'b1;
                if (mode_q) begin
                    remaining_d = reload_q;
                end else begin
                    remaining_d = '0;
                    state_d     = ST_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            reload_q    <= '0;
            mode_q      <= 1'b0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            reload_q    <= reload_d;
            mode_q      <= mode_d;
            expired_q   <= expired_d;
        end
    end

    tick_watchdog #(
        .TIMEOUT (TICK_TIMEOUT)
    ) u_tick_watchdog (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (wd_enable),
        .clear  (start_acc),
        .tick   (tick_1ms),
        .lost   (tick_lost)
    );

    assign busy      = (state_q == ST_RUN);
    assign remaining = remaining_q;
    assign expired   = expired_q;

    // A running interval is never empty and never exceeds its reload value.
    a_run_nonzero : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (remaining_q != '0));
    a_run_bounded : assert property (@(posedge clk) disable iff (!rst_n)
        busy |-> (remaining_q <= reload_q));

endmodule
